// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous
// double buffering, per-slot anti-ghosting blanking and leading-zero blanking.
module display_scan_controller #(
    parameter int DIV = 25000,
    parameter int GAP = 500
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic        lzb,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [17:0] LAST_CNT = 18'(DIV - 1);
    localparam logic [17:0] GAP_END  = 18'(GAP);

    logic [17:0] cnt;
    logic [1:0]  idx;

    logic [15:0] shadow_data;
    logic [3:0]  shadow_dp;
    logic [15:0] pend_data;
    logic [3:0]  pend_dp;
    logic        pending;

    logic        boundary;
    logic        in_gap;
    logic [3:0]  nibble;
    logic [3:0]  blank;
    logic [6:0]  glyph;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'h0:    pattern = 7'h40;
            4'h1:    pattern = 7'h79;
            4'h2:    pattern = 7'h24;
            4'h3:    pattern = 7'h30;
            4'h4:    pattern = 7'h19;
            4'h5:    pattern = 7'h12;
            4'h6:    pattern = 7'h02;
            4'h7:    pattern = 7'h78;
            4'h8:    pattern = 7'h00;
            4'h9:    pattern = 7'h10;
            4'hA:    pattern = 7'h08;
            4'hB:    pattern = 7'h03;
            4'hC:    pattern = 7'h46;
            4'hD:    pattern = 7'h21;
            4'hE:    pattern = 7'h06;
            default: pattern = 7'h0E;
        endcase
        return pattern;
    endfunction

    // The frame boundary is the last cycle of the digit-3 slot while scanning.
    always_comb begin
        boundary = enable && (cnt == LAST_CNT) && (idx == 2'd3);
        in_gap   = (cnt < GAP_END);
    end

    // A digit is blanked only when it and every digit above it are zero;
    // digit 0 always shows so a zero value is still visible.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = lzb && (shadow_data[15:12] == 4'd0);
        blank[2] = blank[3] && (shadow_data[11:8] == 4'd0);
        blank[1] = blank[2] && (shadow_data[7:4] == 4'd0);
        nibble   = shadow_data[{idx, 2'b00} +: 4];
        glyph    = blank[idx] ? 7'h7F : hex_to_seg(nibble);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 18'd1;
        end
    end

    // Outputs lag cnt/idx by one cycle; the gap phase keeps every anode off.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (in_gap) begin
                an  <= 4'hF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end else begin
                an  <= ~(4'b0001 << idx);
                seg <= glyph;
                dp  <= ~shadow_dp[idx];
            end
        end
    end

    // A load on the boundary cycle bypasses the pending buffer; the pending
    // clear is written last so it wins over a simultaneous capture.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            load_ack <= boundary && (load || pending);
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
                pending   <= 1'b1;
            end
            if (boundary && load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
                pending     <= 1'b0;
            end else if (boundary && pending) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
                pending     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a frame-position model of the scan controller.
module tb_display_scan_controller;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * DIV;

    logic        clock_in;
    logic        reset;
    logic        enable;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        lzb;
    logic        load;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    display_scan_controller #(.DIV(DIV), .GAP(GAP)) dut (
        .clock_in   (clock_in),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .lzb        (lzb),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: position within the frame plus the two display buffers
    int          mPos;
    logic [15:0] mShadow;
    logic [3:0]  mShadowDp;
    logic [15:0] mPend;
    logic [3:0]  mPendDp;
    logic        mPending;

    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
    logic        expAck;
    logic        expFd;

    logic        curEn;
    logic        curLz;
    int          ackSeen;

    function automatic logic [6:0] glyphOf(input int digit, input logic [15:0] value, input logic lz);
        logic [15:0] upper;
        upper = value >> (4 * digit);
        if (lz && digit > 0 && upper == 16'd0) return 7'h7F;
        return segTable[upper[3:0]];
    endfunction

    task automatic checkOutput();
        vectors++;
        assert (an === expAn) else begin
            miscompares++;
            $error("[TB] FAIL an: observed %h expected %h at %0t", an, expAn, $time);
        end
        assert (seg === expSeg) else begin
            miscompares++;
            $error("[TB] FAIL seg: observed %h expected %h at %0t", seg, expSeg, $time);
        end
        assert (dp === expDp) else begin
            miscompares++;
            $error("[TB] FAIL dp: observed %b expected %b at %0t", dp, expDp, $time);
        end
        assert (load_ack === expAck) else begin
            miscompares++;
            $error("[TB] FAIL load_ack: observed %b expected %b at %0t", load_ack, expAck, $time);
        end
        assert (frame_done === expFd) else begin
            miscompares++;
            $error("[TB] FAIL frame_done: observed %b expected %b at %0t", frame_done, expFd, $time);
        end
        assert (($countones(~an) <= 1) === 1'b1) else begin
            miscompares++;
            $error("[TB] FAIL one_anode: observed an=%h expected at most one low at %0t", an, $time);
        end
        if (load_ack === 1'b1) ackSeen++;
    endtask

    // Drive one cycle of inputs, advance the model on the same inputs, then
    // compare the registered outputs just after the clock edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                 input logic [15:0] d, input logic [3:0] dpv, input logic lz);
        int  c;
        int  i;
        logic bnd;
        reset   = rst;
        enable  = en;
        load    = ld;
        data_in = d;
        dp_in   = dpv;
        lzb     = lz;

        expAn  = 4'hF;
        expSeg = 7'h7F;
        expDp  = 1'b1;
        expAck = 1'b0;
        expFd  = 1'b0;
        bnd    = 1'b0;
        if (rst) begin
            mPos      = 0;
            mShadow   = '0;
            mShadowDp = '0;
            mPend     = '0;
            mPendDp   = '0;
            mPending  = 1'b0;
        end else begin
            if (en) begin
                c = mPos % DIV;
                i = mPos / DIV;
                if (c >= GAP) begin
                    expAn  = 4'hF ^ (4'b0001 << i);
                    expSeg = glyphOf(i, mShadow, lz);
                    expDp  = ~mShadowDp[i];
                end
                bnd  = (mPos == FRAME - 1);
                mPos = (mPos + 1) % FRAME;
            end else begin
                mPos = 0;
            end
            expFd  = bnd;
            expAck = bnd && (ld || mPending);
            if (bnd && ld) begin
                mShadow   = d;
                mShadowDp = dpv;
                mPending  = 1'b0;
            end else if (bnd && mPending) begin
                mShadow   = mPend;
                mShadowDp = mPendDp;
                mPending  = 1'b0;
            end else if (ld) begin
                mPend    = d;
                mPendDp  = dpv;
                mPending = 1'b1;
            end
        end

        @(posedge clock_in);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, curEn, 1'b0, 16'h0000, 4'h0, curLz);
    endtask

    task automatic doLoad(input logic [15:0] d, input logic [3:0] dpv);
        applyStimulus(1'b0, curEn, 1'b1, d, dpv, curLz);
    endtask

    task automatic waitBoundary();
        int guard;
        guard = 0;
        while (mPos != FRAME - 1 && guard < 2 * FRAME) begin
            idle(1);
            guard++;
        end
    endtask

    initial begin
        int ackBefore;
        reset   = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        data_in = '0;
        dp_in   = '0;
        lzb     = 1'b0;
        curEn   = 1'b0;
        curLz   = 1'b0;
        ackSeen = 0;

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

        $display("[TB] basic scan with load 1234");
        curEn = 1'b1;
        doLoad(16'h1234, 4'h0);
        idle(2 * FRAME + 4);

        $display("[TB] leading-zero blanking");
        curLz = 1'b1;
        doLoad(16'h0070, 4'h0);
        idle(2 * FRAME);
        doLoad(16'h0000, 4'h0);
        idle(2 * FRAME);
        curLz = 1'b0;

        $display("[TB] overwrite before boundary");
        idle(5);
        ackBefore = ackSeen;
        doLoad(16'hAAAA, 4'h0);
        idle(6);
        doLoad(16'hBBBB, 4'h0);
        idle(2 * FRAME);
        assert (ackSeen - ackBefore === 1) else begin
            miscompares++;
            $error("[TB] FAIL single_ack: observed %0d acks expected 1", ackSeen - ackBefore);
        end
        vectors++;

        $display("[TB] load on boundary cycle");
        waitBoundary();
        doLoad(16'hC0DE, 4'h0);
        idle(FRAME + 2);

        $display("[TB] enable toggle");
        idle(11);
        curEn = 1'b0;
        idle(20);
        curEn = 1'b1;
        idle(FRAME + 3);

        $display("[TB] decimal points");
        doLoad(16'h5678, 4'b0101);
        idle(2 * FRAME + 1);

        $display("[TB] reset mid-frame with pending load");
        idle(7);
        doLoad(16'h9999, 4'hF);
        idle(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        ackBefore = ackSeen;
        idle(2 * FRAME + 2);
        assert (ackSeen === ackBefore) else begin
            miscompares++;
            $error("[TB] FAIL no_ack_after_reset: observed %0d acks expected 0", ackSeen - ackBefore);
        end
        vectors++;

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            logic rr;
            logic ld;
            rr    = ($urandom_range(0, 299) == 0);
            curEn = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 63) == 0) curLz = ~curLz;
            ld    = ($urandom_range(0, 7) == 0);
            applyStimulus(rr, curEn, ld, 16'($urandom), 4'($urandom), curLz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes four 7-segment digits on a shared active-low segment bus, one digit at a time.
- Contains its own slot prescaler. Default DIV = 25000 at 50 MHz gives a 2 kHz slot rate and a 500 Hz frame rate.
- Sits between the datapath that produces the displayed value and the board anode/segment pins.
- Double-buffers the displayed value so updates take effect only on frame boundaries. Inserts a blanking gap at the start of each slot to suppress ghosting.

Parameters:
- DIV, 25000, clock cycles per digit slot (min 4, max 2^18-1).
- GAP, 500, blank cycles at the start of each slot, during which all anodes are off (must satisfy 1 <= GAP < DIV).

Ports:
- clock_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  1 = scan running; 0 = display dark, counters held.
- data_in  input  16  four hex nibbles; [3:0] = digit 0 (rightmost).
- dp_in  input  4  decimal point per digit, 1 = lit.
- lzb  input  1  leading-zero blanking enable.
- load  input  1  one-cycle strobe; capture data_in/dp_in for display.
- load_ack  output  1  one-cycle pulse when captured data becomes visible.
- an  output  4  anode enables, active-low; an[i] = digit i.
- seg  output  7  segments, active-low, {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse at end of digit-3 slot.

Behaviour:
- Reset values:
  - an=4'hF, seg=7'h7F, dp=1, load_ack=0, frame_done=0.
  - cnt=0, idx=0.
  - shadow data/dp=0, pending flag=0.
- Registers:
  - cnt is 18 bits, counts 0..DIV-1 and wraps to 0.
  - idx is 2 bits and increments by 1 when cnt wraps; 3 wraps to 0.
- Slot phases:
  - GAP phase, cnt < GAP: an=4'hF, seg=7'h7F, dp=1.
  - ON phase, cnt >= GAP: an = ~(1<<idx); seg/dp = decode of the shadow nibble idx.
  - All outputs are registered, one cycle after cnt/idx.
- Frame boundary: cnt==DIV-1 and idx==3.
  - frame_done=1 on the following cycle only.
- Load handshake:
  - load=1 copies data_in/dp_in into the pending registers and sets the pending flag. A later load before the boundary overwrites them; last wins.
  - At a frame boundary, if load=1 that same cycle, data_in/dp_in go directly into shadow. Otherwise, if pending=1, the pending registers go into shadow.
  - Pending clears on that shadow update.
  - load_ack=1 on the cycle after any shadow update; otherwise 0.
  - A load with no boundary yet: no ack until the boundary.
- Decode, hex, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78.
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E (hex values of seg).
- Leading-zero blanking (lzb=1):
  - Digit i (i>=1) is blanked (seg=7'h7F) when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp still follows shadow dp for blanked digits.
  - Evaluated on the shadow registers.
- enable=0:
  - cnt, idx forced to 0; an=4'hF, seg=7'h7F, dp=1; frame_done=0.
  - load capture still works; the shadow update waits for a boundary.
- Enable rising: scan restarts at idx=0, cnt=0, beginning with a GAP phase.
- Reset mid-frame: all state returns to reset values next cycle; pending loads are discarded and no load_ack is issued.
- Exactly one anode is low at any time in the ON phase; never more than one.

Test Plan:
- Reset and timing:
  - Stimulus: DIV=8, GAP=2, reset then enable=1, load data_in=16'h1234.
  - Response: first frame shows 0 on all digits. After the first boundary, load_ack pulses once. The next frame shows an=E seg=19, an=D seg=30, an=B seg=24, an=7 seg=79. Each slot is 2 blank cycles plus 6 lit; frame_done every 32 cycles.
- Leading-zero blanking:
  - Stimulus: lzb=1, data 16'h0070.
  - Response: digits 3,2 seg=7F; digit 1 seg=78; digit 0 seg=40.
  - Stimulus: data 16'h0000.
  - Response: only digit 0 shows 40.
- Load timing:
  - Stimulus: load 16'hAAAA mid-frame, then 16'hBBBB before the boundary.
  - Response: a single load_ack; BBBB is displayed (03 on all digits).
  - Stimulus: load asserted exactly on the boundary cycle.
  - Response: applied that boundary, ack next cycle.
- Enable toggle:
  - Stimulus: enable=0 for 20 cycles mid-slot.
  - Response: an=F, seg=7F, dp=1 while low. On re-enable, the first lit digit is digit 0 after 2 blank cycles.
- Reset mid-frame:
  - Stimulus: reset asserted mid-frame with a pending load.
  - Response: outputs at reset values next cycle; shadow=0; no load_ack afterwards.
- Decimal point:
  - Stimulus: dp_in=4'b0101.
  - Response: dp=0 only during the ON phase of digits 0 and 2; dp=1 in all GAP phases.
